// File: rtl/matrix_load_sched_if.sv
// Host command/data stream and operand-buffer write port of the LilME load sequencer.
// The host-side modport drives commands and data; the sequencer uses the slave modport.
interface matrix_load_sched_if;
   logic        cmd_valid;
   logic [1:0]  cmd_op;
   logic        cmd_ready;
   logic        din_valid;
   logic [31:0] din;
   logic        din_ready;
   logic        a_opcode;
   logic [31:0] a_data;
   logic        b_opcode;
   logic [31:0] b_data;
   logic        run_start;
   logic        run_done;
   logic        busy;
   logic        done;
   logic        err;
   logic        loaded_a;
   logic        loaded_b;

   modport master (
      output cmd_valid, cmd_op, din_valid, din, run_done,
      input  cmd_ready, din_ready, a_opcode, a_data, b_opcode, b_data,
             run_start, busy, done, err, loaded_a, loaded_b
   );

   modport slave (
      input  cmd_valid, cmd_op, din_valid, din, run_done,
      output cmd_ready, din_ready, a_opcode, a_data, b_opcode, b_data,
             run_start, busy, done, err, loaded_a, loaded_b
   );
endinterface

// File: rtl/matrix_load_sched.sv
// Sequencer that streams N_WORDS words into operand buffer A or B and starts a compute
// once both operands are loaded. Only one command is in flight at a time.
//
// state       | meaning
// ------------+---------------------------------------------------------
// S_IDLE      | ready for a command
// S_LOAD_A    | accepting din words for buffer A
// S_LOAD_B    | accepting din words for buffer B
// S_RUN_START | run_start high this cycle, operand flags cleared
// S_RUN_WAIT  | waiting for run_done
module matrix_load_sched #(
   parameter int N_WORDS = 4
) (
   input logic               clk,
   input logic               n_reset,
   matrix_load_sched_if.slave bus
);
   localparam int CW = (N_WORDS > 2) ? $clog2(N_WORDS) : 1;
   localparam logic [CW-1:0] LAST = CW'(N_WORDS - 1);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_LOAD_A    = 3'd1;
   localparam logic [2:0] S_LOAD_B    = 3'd2;
   localparam logic [2:0] S_RUN_START = 3'd3;
   localparam logic [2:0] S_RUN_WAIT  = 3'd4;

   logic [2:0]    r_state;
   logic [CW-1:0] r_cnt;
   logic          r_a_opcode;
   logic [31:0]   r_a_data;
   logic          r_b_opcode;
   logic [31:0]   r_b_data;
   logic          r_run_start;
   logic          r_done;
   logic          r_err;
   logic          r_loaded_a;
   logic          r_loaded_b;
   logic          w_last;

   assign w_last = (r_cnt == LAST);

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_a_opcode  <= 1'b0;
         r_a_data    <= '0;
         r_b_opcode  <= 1'b0;
         r_b_data    <= '0;
         r_run_start <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_loaded_a  <= 1'b0;
         r_loaded_b  <= 1'b0;
      end else begin
         r_a_opcode  <= 1'b0;
         r_b_opcode  <= 1'b0;
         r_run_start <= 1'b0;
         r_done      <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.cmd_valid) begin
                  case (bus.cmd_op)
                     2'b00: begin
                        r_cnt   <= '0;
                        r_state <= S_LOAD_A;
                     end
                     2'b01: begin
                        r_cnt   <= '0;
                        r_state <= S_LOAD_B;
                     end
                     2'b10: begin
                        // run_start is registered so it is high exactly in S_RUN_START
                        if (r_loaded_a && r_loaded_b) begin
                           r_run_start <= 1'b1;
                           r_state     <= S_RUN_START;
                        end else begin
                           r_err <= 1'b1;
                        end
                     end
                     default: r_err <= 1'b1;
                  endcase
               end
            end
            S_LOAD_A: begin
               if (bus.din_valid) begin
                  r_a_opcode <= 1'b1;
                  r_a_data   <= bus.din;
                  if (w_last) begin
                     r_cnt      <= '0;
                     r_loaded_a <= 1'b1;
                     r_done     <= 1'b1;
                     r_state    <= S_IDLE;
                  end else begin
                     r_cnt <= r_cnt + CW'(1);
                  end
               end
            end
            S_LOAD_B: begin
               if (bus.din_valid) begin
                  r_b_opcode <= 1'b1;
                  r_b_data   <= bus.din;
                  if (w_last) begin
                     r_cnt      <= '0;
                     r_loaded_b <= 1'b1;
                     r_done     <= 1'b1;
                     r_state    <= S_IDLE;
                  end else begin
                     r_cnt <= r_cnt + CW'(1);
                  end
               end
            end
            S_RUN_START: begin
               r_loaded_a <= 1'b0;
               r_loaded_b <= 1'b0;
               r_state    <= S_RUN_WAIT;
            end
            S_RUN_WAIT: begin
               if (bus.run_done) begin
                  r_done  <= 1'b1;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.cmd_ready = (r_state == S_IDLE);
   assign bus.din_ready = (r_state == S_LOAD_A) || (r_state == S_LOAD_B);
   assign bus.busy      = (r_state != S_IDLE);
   assign bus.a_opcode  = r_a_opcode;
   assign bus.a_data    = r_a_data;
   assign bus.b_opcode  = r_b_opcode;
   assign bus.b_data    = r_b_data;
   assign bus.run_start = r_run_start;
   assign bus.done      = r_done;
   assign bus.err       = r_err;
   assign bus.loaded_a  = r_loaded_a;
   assign bus.loaded_b  = r_loaded_b;
endmodule

// File: tb/tb_matrix_load_sched.sv
// Scoreboard bench for matrix_load_sched: stimulus queues expected strobes/pulses with
// their cycle stamps, a negedge monitor pops and compares whenever the DUT emits one.
module tb_matrix_load_sched;
   typedef struct {
      int          cyc;
      logic [31:0] data;
   } ev_t;

   logic clk;
   logic n_reset;
   int   cyc;
   int   n_tot;
   int   n_pass;
   ev_t  qa[$];
   ev_t  qb[$];
   int   qdone[$];
   int   qrun[$];
   ev_t  m_e;
   int   m_c;

   matrix_load_sched_if bus ();

   matrix_load_sched #(.N_WORDS(4)) dut (
      .clk     (clk),
      .n_reset (n_reset),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish by time %0t, expected finish", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act !== exp)
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      else
         n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every emitted strobe/pulse must match the head of its queue
   always @(negedge clk) begin
      if (n_reset) begin
         if (bus.a_opcode) begin
            n_tot++;
            if (qa.size() == 0) begin
               $display("FAIL a_strobe: got strobe data %h at cycle %0d, expected none", bus.a_data, cyc);
            end else begin
               m_e = qa.pop_front();
               if (m_e.cyc != cyc || m_e.data !== bus.a_data)
                  $display("FAIL a_strobe: got cycle %0d data %h, expected cycle %0d data %h", cyc, bus.a_data, m_e.cyc, m_e.data);
               else
                  n_pass++;
            end
         end
         if (bus.b_opcode) begin
            n_tot++;
            if (qb.size() == 0) begin
               $display("FAIL b_strobe: got strobe data %h at cycle %0d, expected none", bus.b_data, cyc);
            end else begin
               m_e = qb.pop_front();
               if (m_e.cyc != cyc || m_e.data !== bus.b_data)
                  $display("FAIL b_strobe: got cycle %0d data %h, expected cycle %0d data %h", cyc, bus.b_data, m_e.cyc, m_e.data);
               else
                  n_pass++;
            end
         end
         if (bus.done) begin
            n_tot++;
            if (qdone.size() == 0) begin
               $display("FAIL done: got pulse at cycle %0d, expected none", cyc);
            end else begin
               m_c = qdone.pop_front();
               if (m_c != cyc)
                  $display("FAIL done: got cycle %0d, expected cycle %0d", cyc, m_c);
               else
                  n_pass++;
            end
         end
         if (bus.run_start) begin
            n_tot++;
            if (qrun.size() == 0) begin
               $display("FAIL run_start: got pulse at cycle %0d, expected none", cyc);
            end else begin
               m_c = qrun.pop_front();
               if (m_c != cyc)
                  $display("FAIL run_start: got cycle %0d, expected cycle %0d", cyc, m_c);
               else
                  n_pass++;
            end
         end
      end
   end

   task automatic send_cmd(input logic [1:0] op);
      int t;
      t = 0;
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      while (!bus.cmd_ready && t < 20) begin
         tick();
         t++;
      end
      if (t >= 20) begin
         n_tot++;
         $display("FAIL cmd_timeout: got cmd_ready 0 for %0d cycles, expected 1", t);
      end
      if (op == 2'b10 && bus.loaded_a && bus.loaded_b) qrun.push_back(cyc + 1);
      tick();
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 2'b00;
   endtask

   // Words are base*1 .. base*4; nsend < 4 leaves the load unfinished
   task automatic load(input logic [1:0] op, input logic [31:0] base, input bit gap, input int nsend);
      int   t;
      ev_t  e;
      send_cmd(op);
      chk("din_ready_after_cmd", {31'b0, bus.din_ready}, 32'd1);
      for (int i = 0; i < nsend; i++) begin
         if (gap && i > 0) begin
            bus.din_valid = 1'b0;
            tick();
         end
         bus.din_valid = 1'b1;
         bus.din       = 32'(base * 32'(i + 1));
         t = 0;
         while (!bus.din_ready && t < 20) begin
            tick();
            t++;
         end
         if (t >= 20) begin
            n_tot++;
            $display("FAIL din_timeout: got din_ready 0 for %0d cycles, expected 1", t);
         end
         e.cyc  = cyc + 1;
         e.data = bus.din;
         if (op == 2'b00) qa.push_back(e);
         else             qb.push_back(e);
         if (i == 3) qdone.push_back(cyc + 1);
         tick();
      end
      bus.din_valid = 1'b0;
   endtask

   initial begin
      n_tot = 0;
      n_pass = 0;
      n_reset = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 2'b00;
      bus.din_valid = 1'b0;
      bus.din       = '0;
      bus.run_done  = 1'b0;
      #12;
      chk("rst_a_opcode", {31'b0, bus.a_opcode}, 32'd0);
      chk("rst_a_data", bus.a_data, 32'd0);
      chk("rst_b_opcode", {31'b0, bus.b_opcode}, 32'd0);
      chk("rst_b_data", bus.b_data, 32'd0);
      chk("rst_run_start", {31'b0, bus.run_start}, 32'd0);
      chk("rst_done_err_loaded", {28'b0, bus.done, bus.err, bus.loaded_a, bus.loaded_b}, 32'd0);
      chk("rst_cmd_ready", {31'b0, bus.cmd_ready}, 32'd1);
      chk("rst_busy_din_ready", {30'b0, bus.busy, bus.din_ready}, 32'd0);
      @(negedge clk);
      n_reset = 1'b1;
      tick();

      // Load A continuous, then load B with gaps accepted back-to-back with done
      load(2'b00, 32'h11, 1'b0, 4);
      chk("loaded_a_after_A", {30'b0, bus.loaded_a, bus.loaded_b}, 32'b10);
      load(2'b01, 32'h55, 1'b1, 4);
      chk("loaded_after_B", {30'b0, bus.loaded_a, bus.loaded_b}, 32'b11);
      chk("a_data_held", bus.a_data, 32'h44);
      chk("b_data_last", bus.b_data, 32'h154);

      // run_done outside RUN_WAIT must be ignored
      bus.run_done = 1'b1;
      tick();
      bus.run_done = 1'b0;
      tick();
      chk("stray_run_done_busy", {31'b0, bus.busy}, 32'd0);

      send_cmd(2'b10);
      chk("run_start_busy", {31'b0, bus.busy}, 32'd1);
      tick();
      chk("run_loaded_cleared", {30'b0, bus.loaded_a, bus.loaded_b}, 32'b00);
      for (int i = 0; i < 4; i++) begin
         chk("run_wait_busy", {31'b0, bus.busy}, 32'd1);
         tick();
      end
      bus.run_done = 1'b1;
      qdone.push_back(cyc + 1);
      tick();
      bus.run_done = 1'b0;
      chk("run_done_idle", {31'b0, bus.busy}, 32'd0);
      chk("err_before", {31'b0, bus.err}, 32'd0);

      // Run with only A loaded, then reserved op
      load(2'b00, 32'h101, 1'b0, 4);
      send_cmd(2'b10);
      chk("err_run_not_loaded", {31'b0, bus.err}, 32'd1);
      chk("err_cmd_ready", {31'b0, bus.cmd_ready}, 32'd1);
      chk("err_loaded_a_kept", {31'b0, bus.loaded_a}, 32'd1);
      send_cmd(2'b11);
      chk("err_sticky", {31'b0, bus.err}, 32'd1);
      chk("err_op11_cmd_ready", {31'b0, bus.cmd_ready}, 32'd1);
      tick();

      // Reset in the middle of a B load
      load(2'b01, 32'h77, 1'b0, 2);
      @(negedge clk);
      #1;
      n_reset = 1'b0;
      #1;
      chk("mid_rst_strobes", {30'b0, bus.a_opcode, bus.b_opcode}, 32'd0);
      chk("mid_rst_b_data", bus.b_data, 32'd0);
      chk("mid_rst_a_data", bus.a_data, 32'd0);
      chk("mid_rst_flags", {28'b0, bus.err, bus.loaded_a, bus.loaded_b, bus.done}, 32'd0);
      chk("mid_rst_busy", {30'b0, bus.busy, bus.din_ready}, 32'd0);
      tick();
      tick();
      @(negedge clk);
      n_reset = 1'b1;
      tick();
      tick();
      load(2'b00, 32'hA1, 1'b0, 4);
      chk("post_rst_loaded", {30'b0, bus.loaded_a, bus.loaded_b}, 32'b10);
      chk("post_rst_a_data", bus.a_data, 32'h284);
      repeat (4) tick();

      chk("qa_empty", 32'(qa.size()), 32'd0);
      chk("qb_empty", 32'(qb.size()), 32'd0);
      chk("qdone_empty", 32'(qdone.size()), 32'd0);
      chk("qrun_empty", 32'(qrun.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
